switch_alloc_rr: RTL and testbench
==================================

SWITCH_ALLOC_RR -- requirements
Module: switch_alloc_rr

Interface
REQ-001 SHALL have parameter CREDIT_DEPTH, default 4: downstream input-buffer depth in flits, and the initial and maximum credit count per output.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_output_req, input, [0:`N-1][0:`N-1]: per input, a one-hot requested output port, as produced by the selection stage.
REQ-005 SHALL have port i_valid, input, [0:`N-1]: the input holds a flit at its head.
REQ-006 SHALL have port i_tail, input, [0:`N-1]: the head flit of that input is a tail flit.
REQ-007 SHALL have port i_credit_ret, input, [0:`N-1]: per output, one credit returned by the downstream router.
REQ-008 SHALL have port o_grant, output, [0:`N-1][0:`N-1]: registered grant, indexed [input][output].
REQ-009 SHALL have port o_in_grant, output, [0:`N-1]: OR-reduction of o_grant per input, meaning "pop head flit".
REQ-010 SHALL have port o_credit_cnt, output, [0:`N-1][$clog2(CREDIT_DEPTH+1)-1:0]: current credits per output.
REQ-011 SHALL have port o_locked, output, [0:`N-1]: per output, a wormhole lock is held.

Function
REQ-012 SHALL treat an input as requesting only when i_valid=1; if more than one i_output_req bit is set, it SHALL use the lowest index.
REQ-013 SHALL ignore a request from input i to output i (U-turn).
REQ-014 SHALL compute arbitration from inputs sampled at edge t and present o_grant in the cycle after edge t: one-cycle latency, at most one grant per output and per input.
REQ-015 Each output SHALL run FSM IDLE/LOCKED with a registered owner field and a round-robin pointer rr_ptr.
REQ-016 In IDLE, an output with credit>0 SHALL grant the first requester at or after rr_ptr, wrapping modulo `N.
REQ-017 An IDLE grant with i_tail=0 SHALL move the output to LOCKED with owner set to the winner; with i_tail=1 (single-flit packet) it SHALL stay IDLE.
REQ-018 In LOCKED, the output SHALL grant only the owner, and only while the owner requests it and credit>0; other requesters SHALL be blocked.
REQ-019 A LOCKED grant with i_tail=1 SHALL return the output to IDLE.
REQ-020 rr_ptr SHALL update to (winner+1) mod `N only when a packet completes (tail granted); it SHALL be unchanged otherwise.
REQ-021 Credit count SHALL decrement on a grant and increment on i_credit_ret; on simultaneous grant and return it SHALL stay unchanged.
REQ-022 No grant SHALL be issued at credit=0; a return arriving at credit=CREDIT_DEPTH SHALL be dropped, saturating at the maximum.
REQ-023 An input SHALL win at most one output per cycle; since requests are one-hot, no conflict arises.

Reset
REQ-024 On reset_n=0, asynchronously: o_grant=0, o_in_grant=0, o_locked=0, all FSMs IDLE, owner=0, rr_ptr=0, o_credit_cnt=CREDIT_DEPTH.
REQ-025 Reset mid-packet SHALL drop all locks; the first grant after reset release SHALL come no earlier than the second rising edge.

Configuration
REQ-026 Macro SW_ALLOC_CREDIT_EN: when defined, credit counting per REQ-021/022 SHALL apply.
REQ-027 When SW_ALLOC_CREDIT_EN is undefined, credit SHALL be treated as always available, i_credit_ret ignored, and o_credit_cnt tied to CREDIT_DEPTH.

Verification
REQ-028 Inputs 1 and 2 request output 3 with single-flit packets, held for 4 cycles after reset -> grants alternate 1,2,1,2.
REQ-029 Input 0 sends a 3-flit packet to output 4 while input 2 also requests output 4 -> input 0 is granted 3 consecutive cycles, o_locked[4]=1 until the tail, then input 2 is granted.
REQ-030 With SW_ALLOC_CREDIT_EN, CREDIT_DEPTH=4, input 1 streams to output 2 with no returns -> exactly 4 grants and o_credit_cnt[2]=0; one i_credit_ret -> exactly one more grant.
REQ-031 Grant and credit return on the same cycle at count 2 -> count stays 2; a return at count 4 -> count stays 4.
REQ-032 reset_n pulsed low while output 3 is LOCKED mid-packet -> o_locked=0, counts=CREDIT_DEPTH, and rr_ptr=0 immediately.
REQ-033 Input 2 requests output 2 only -> no grant is ever issued.

Source files
------------

// File: rtl/switch_alloc_rr.sv
// Per-output round-robin switch allocator with wormhole locking and optional
// per-output credit counting (enabled by defining SW_ALLOC_CREDIT_EN).
`ifndef N
`define N 5
`endif

module switch_alloc_rr #(
    parameter int CREDIT_DEPTH = 4
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [0:`N-1][0:`N-1]                         i_output_req,
    input  logic [0:`N-1]                                 i_valid,
    input  logic [0:`N-1]                                 i_tail,
    input  logic [0:`N-1]                                 i_credit_ret,
    output logic [0:`N-1][0:`N-1]                         o_grant,
    output logic [0:`N-1]                                 o_in_grant,
    output logic [0:`N-1][$clog2(CREDIT_DEPTH+1)-1:0]     o_credit_cnt,
    output logic [0:`N-1]                                 o_locked
);
    localparam int N  = `N;
    localparam int CW = $clog2(CREDIT_DEPTH + 1);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t                r_state     [0:N-1];
    state_t                w_state_nxt [0:N-1];
    logic [0:N-1][PW-1:0]  r_owner;
    logic [0:N-1][PW-1:0]  w_owner_nxt;
    logic [0:N-1][PW-1:0]  r_rr_ptr;
    logic [0:N-1][PW-1:0]  w_rr_ptr_nxt;
    logic [0:N-1][0:N-1]   w_req;        // [output][input]
    logic [0:N-1][0:N-1]   w_grant_nxt;  // [input][output]
    logic [0:N-1]          w_out_gnt;
    logic [0:N-1]          w_has_credit;
    logic                  r_arm;

    // Decode requests: valid inputs only, lowest set bit wins, U-turns dropped
    always_comb begin
        logic found;
        w_req = '0;
        for (int i = 0; i < N; i++) begin
            found = 1'b0;
            if (i_valid[i]) begin
                for (int o = 0; o < N; o++) begin
                    if (!found && i_output_req[i][o]) begin
                        found = 1'b1;
                        if (o != i) begin
                            w_req[o][i] = 1'b1;
                        end else begin
                            w_req[o][i] = 1'b0;
                        end
                    end else begin
                        found = found;
                    end
                end
            end else begin
                found = 1'b0;
            end
        end
    end

    // Per-output FSM next state, arbitration and pointer/owner updates
    always_comb begin
        logic win_found;
        int   win;
        int   idx;
        w_grant_nxt = '0;
        w_out_gnt   = '0;
        for (int o = 0; o < N; o++) begin
            w_state_nxt[o]  = r_state[o];
            w_owner_nxt[o]  = r_owner[o];
            w_rr_ptr_nxt[o] = r_rr_ptr[o];
            win_found       = 1'b0;
            win             = 0;
            idx             = 0;
            case (r_state[o])
                ST_IDLE: begin
                    if (r_arm && w_has_credit[o]) begin
                        for (int k = 0; k < N; k++) begin
                            idx = int'(r_rr_ptr[o]) + k;
                            if (idx >= N) begin
                                idx = idx - N;
                            end else begin
                                idx = idx;
                            end
                            if (!win_found && w_req[o][idx]) begin
                                win_found = 1'b1;
                                win       = idx;
                            end else begin
                                win_found = win_found;
                            end
                        end
                    end else begin
                        win_found = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (r_arm && w_has_credit[o] && w_req[o][r_owner[o]]) begin
                        win_found = 1'b1;
                        win       = int'(r_owner[o]);
                    end else begin
                        win_found = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt[o] = ST_IDLE;
                end
            endcase
            if (win_found) begin
                w_grant_nxt[win][o] = 1'b1;
                w_out_gnt[o]        = 1'b1;
                if (i_tail[win]) begin
                    w_state_nxt[o]  = ST_IDLE;
                    w_rr_ptr_nxt[o] = (win == N - 1) ? PW'(0) : PW'(win + 1);
                end else begin
                    w_state_nxt[o] = ST_LOCKED;
                    w_owner_nxt[o] = PW'(win);
                end
            end else begin
                w_out_gnt[o] = 1'b0;
            end
        end
    end

    // State, owner, pointer and registered grant outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < N; o++) begin
                r_state[o] <= ST_IDLE;
            end
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            o_grant    <= '0;
            o_in_grant <= '0;
            r_arm      <= 1'b0;
        end else begin
            for (int o = 0; o < N; o++) begin
                r_state[o] <= w_state_nxt[o];
            end
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            o_grant  <= w_grant_nxt;
            for (int i = 0; i < N; i++) begin
                o_in_grant[i] <= |w_grant_nxt[i];
            end
            r_arm <= 1'b1;
        end
    end

    always_comb begin
        for (int o = 0; o < N; o++) begin
            o_locked[o] = (r_state[o] == ST_LOCKED);
        end
    end

`ifdef SW_ALLOC_CREDIT_EN
    logic [0:N-1][CW-1:0] r_credit;

    always_comb begin
        for (int o = 0; o < N; o++) begin
            w_has_credit[o] = (r_credit[o] != CW'(0));
        end
    end

    // Credit counters: grant consumes, return refills, saturate at depth
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < N; o++) begin
                r_credit[o] <= CW'(CREDIT_DEPTH);
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                if (w_out_gnt[o] && !i_credit_ret[o]) begin
                    r_credit[o] <= r_credit[o] - CW'(1);
                end else if (!w_out_gnt[o] && i_credit_ret[o] &&
                             (r_credit[o] < CW'(CREDIT_DEPTH))) begin
                    r_credit[o] <= r_credit[o] + CW'(1);
                end else begin
                    r_credit[o] <= r_credit[o];
                end
            end
        end
    end

    assign o_credit_cnt = r_credit;
`else
    logic w_unused_credit_ret;
    assign w_unused_credit_ret = ^{i_credit_ret, w_out_gnt};
    assign w_has_credit        = '1;

    always_comb begin
        for (int o = 0; o < N; o++) begin
            o_credit_cnt[o] = CW'(CREDIT_DEPTH);
        end
    end
`endif

endmodule

// File: tb/tb_switch_alloc_rr.sv
// Directed self-checking bench for switch_alloc_rr (default and credit builds).
`ifndef N
`define N 5
`endif

module tb_switch_alloc_rr;
    localparam int N     = `N;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef logic [0:N-1][0:N-1]  gmat_t;
    typedef logic [0:N-1]         vec_t;
    typedef logic [0:N-1][CW-1:0] cnt_t;

    logic  clk = 1'b0;
    logic  reset_n;
    gmat_t i_output_req;
    vec_t  i_valid, i_tail, i_credit_ret;
    gmat_t o_grant;
    vec_t  o_in_grant, o_locked;
    cnt_t  o_credit_cnt;

    int n_total = 0;
    int n_bad   = 0;

    switch_alloc_rr #(.CREDIT_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_output_req (i_output_req),
        .i_valid      (i_valid),
        .i_tail       (i_tail),
        .i_credit_ret (i_credit_ret),
        .o_grant      (o_grant),
        .o_in_grant   (o_in_grant),
        .o_credit_cnt (o_credit_cnt),
        .o_locked     (o_locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic gmat_t gm(input int i, input int o);
        gmat_t g;
        g       = '0;
        g[i][o] = 1'b1;
        return g;
    endfunction

    function automatic vec_t vb(input int i);
        vec_t v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic cnt_t full_cnt();
        cnt_t c;
        for (int o = 0; o < N; o++) c[o] = CW'(DEPTH);
        return c;
    endfunction

    task automatic clear_in();
        i_output_req = '0;
        i_valid      = '0;
        i_tail       = '0;
        i_credit_ret = '0;
    endtask

    task automatic set_req(input int i, input int o, input logic tail);
        i_output_req[i]    = '0;
        i_output_req[i][o] = 1'b1;
        i_valid[i]         = 1'b1;
        i_tail[i]          = tail;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        reset_n = 1'b0;
        clear_in();
        @(posedge clk);
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int left;

    initial begin
        clear_in();
        reset_n = 1'b0;
        #12;
        chk("rst_grant",   64'(o_grant),      64'd0);
        chk("rst_in_gnt",  64'(o_in_grant),   64'd0);
        chk("rst_locked",  64'(o_locked),     64'd0);
        chk("rst_credits", 64'(o_credit_cnt), 64'(full_cnt()));

        // Alternating single-flit grants from inputs 1 and 2 on output 3
        set_req(1, 3, 1'b1);
        set_req(2, 3, 1'b1);
        release_reset();
        tick();
        chk("first_edge_quiet", 64'(o_grant), 64'd0);
        tick(); chk("rr_g1", 64'(o_grant), 64'(gm(1, 3)));
        chk("rr_in_gnt", 64'(o_in_grant), 64'(vb(1)));
        tick(); chk("rr_g2", 64'(o_grant), 64'(gm(2, 3)));
        tick(); chk("rr_g3", 64'(o_grant), 64'(gm(1, 3)));
        tick(); chk("rr_g4", 64'(o_grant), 64'(gm(2, 3)));

        // Three-flit wormhole from input 0 to output 4 with input 2 contending
        hold_reset();
        set_req(0, 4, 1'b0);
        set_req(2, 4, 1'b1);
        left = 3;
        release_reset();
        tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("worm_grant", 64'(o_grant), 64'(gm(0, 4)));
            chk("worm_lock", 64'(o_locked[4]), (c < 2) ? 64'd1 : 64'd0);
            left--;
            if (left == 1) i_tail[0] = 1'b1;
            if (left == 0) i_valid[0] = 1'b0;
        end
        tick();
        chk("worm_next", 64'(o_grant), 64'(gm(2, 4)));
        i_valid[2] = 1'b0;
        tick();
        chk("worm_idle", 64'(o_grant), 64'd0);

        // U-turn request is never granted
        hold_reset();
        set_req(2, 2, 1'b1);
        release_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("uturn", 64'(o_grant), 64'd0);
        end

`ifdef SW_ALLOC_CREDIT_EN
        // Credit exhaustion and a single refill
        hold_reset();
        set_req(1, 2, 1'b1);
        release_reset();
        tick();
        for (int c = 0; c < DEPTH; c++) begin
            tick();
            chk("cred_grant", 64'(o_grant), 64'(gm(1, 2)));
            chk("cred_cnt", 64'(o_credit_cnt[2]), 64'(DEPTH - 1 - c));
        end
        tick(); chk("cred_empty", 64'(o_grant), 64'd0);
        i_credit_ret[2] = 1'b1;
        tick();
        i_credit_ret[2] = 1'b0;
        chk("cred_ret_cnt", 64'(o_credit_cnt[2]), 64'd1);
        chk("cred_ret_nogrant", 64'(o_grant), 64'd0);
        tick(); chk("cred_refill_grant", 64'(o_grant), 64'(gm(1, 2)));
        chk("cred_refill_cnt", 64'(o_credit_cnt[2]), 64'd0);
        tick(); chk("cred_refill_once", 64'(o_grant), 64'd0);

        // Simultaneous grant and return at count 2, return at full count
        hold_reset();
        set_req(1, 2, 1'b1);
        release_reset();
        tick();
        tick(); tick();
        chk("sim_pre", 64'(o_credit_cnt[2]), 64'd2);
        i_credit_ret[2] = 1'b1;
        tick();
        chk("sim_grant", 64'(o_grant), 64'(gm(1, 2)));
        chk("sim_cnt", 64'(o_credit_cnt[2]), 64'd2);
        hold_reset();
        i_credit_ret[2] = 1'b1;
        release_reset();
        tick(); tick();
        chk("sat_cnt", 64'(o_credit_cnt[2]), 64'(DEPTH));
        i_credit_ret[2] = 1'b0;
`else
        // Credits are unlimited and returns ignored
        hold_reset();
        set_req(1, 2, 1'b1);
        release_reset();
        tick();
        for (int c = 0; c < DEPTH + 2; c++) begin
            i_credit_ret[2] = c[0];
            tick();
            chk("nocred_grant", 64'(o_grant), 64'(gm(1, 2)));
            chk("nocred_cnt", 64'(o_credit_cnt[2]), 64'(DEPTH));
        end
`endif

        // Reset while output 3 is locked mid-packet
        hold_reset();
        set_req(2, 3, 1'b1);
        release_reset();
        tick();
        tick(); chk("pre_single", 64'(o_grant), 64'(gm(2, 3)));
        i_valid[2] = 1'b0;
        set_req(4, 3, 1'b0);
        tick(); chk("pre_lock_grant", 64'(o_grant), 64'(gm(4, 3)));
        chk("pre_locked", 64'(o_locked[3]), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_locked", 64'(o_locked), 64'd0);
        chk("mid_rst_grant", 64'(o_grant), 64'd0);
        chk("mid_rst_cnt", 64'(o_credit_cnt), 64'(full_cnt()));
        clear_in();
        set_req(1, 3, 1'b1);
        set_req(4, 3, 1'b1);
        release_reset();
        tick(); chk("post_rst_quiet", 64'(o_grant), 64'd0);
        tick(); chk("post_rst_ptr0", 64'(o_grant), 64'(gm(1, 3)));
        clear_in();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
